// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//
// Conditions one raw, active-low, bouncy pushbutton into clean signals for
// downstream FSM and counter logic: a debounced pressed level, single-cycle
// press and release strobes, and a single-cycle long-press strobe.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous reset, active-high
//   key_n          in   raw pushbutton, 0 = pressed, asynchronous to clk
//   level          out  debounced pressed state, 1 = pressed
//   press_pulse    out  one-cycle strobe on accepted press (and auto-repeat)
//   release_pulse  out  one-cycle strobe on accepted release
//   long_pulse     out  one-cycle strobe once the key is held LONG_CYCLES
//
// Optional feature: define KEY_DEBOUNCE_AUTOREPEAT_EN to re-issue press_pulse
// every REPEAT_CYCLES while the key stays held after long_pulse. Without the
// macro no repeat logic exists and REPEAT_CYCLES is not a parameter.
//
// DEBOUNCE_CYCLES must be >= 2; CNT_W must hold the largest cycle parameter.

module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 10_000_000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    // Hold counter parks here so the long-press compare can never match again.
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             pressedS;
    logic [1:0]       state_q,        state_d;
    logic [CNT_W-1:0] debounceCnt_q,  debounceCnt_d;
    logic [CNT_W-1:0] holdCnt_q,      holdCnt_d;
    logic             level_q,        level_d;
    logic             pressPulse_q,   pressPulse_d;
    logic             releasePulse_q, releasePulse_d;
    logic             longPulse_q,    longPulse_d;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    logic [CNT_W-1:0] repeatCnt_q,    repeatCnt_d;
`endif

    // Two-flop synchroniser; resets to the released (high) level so a held key
    // after reset is seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta_q <= 1'b1;
            syncOut_q  <= 1'b1;
        end else begin
            syncMeta_q <= key_n;
            syncOut_q  <= syncMeta_q;
        end
    end

    assign pressedS = ~syncOut_q;

    always_comb begin
        state_d        = state_q;
        debounceCnt_d  = debounceCnt_q;
        holdCnt_d      = holdCnt_q;
        level_d        = level_q;
        pressPulse_d   = 1'b0;
        releasePulse_d = 1'b0;
        longPulse_d    = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        repeatCnt_d    = repeatCnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pressedS) begin
                    state_d       = ST_PRESS_WAIT;
                    debounceCnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressedS) begin
                    state_d = ST_IDLE;
                end else if (debounceCnt_q == DEB_LAST) begin
                    state_d      = ST_HELD;
                    level_d      = 1'b1;
                    pressPulse_d = 1'b1;
                    holdCnt_d    = '0;
                end else begin
                    debounceCnt_d = debounceCnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (holdCnt_q != LONG_SAT) begin
                    holdCnt_d = holdCnt_q + CNT_ONE;
                end
                if (holdCnt_q == LONG_LAST) begin
                    longPulse_d = 1'b1;
                end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                // Repeat phase starts at the long pulse and only runs once the
                // hold counter has saturated.
                if (holdCnt_q == LONG_LAST) begin
                    repeatCnt_d = '0;
                end else if (holdCnt_q == LONG_SAT) begin
                    if (repeatCnt_q == REP_LAST) begin
                        pressPulse_d = 1'b1;
                        repeatCnt_d  = '0;
                    end else begin
                        repeatCnt_d = repeatCnt_q + CNT_ONE;
                    end
                end
`endif
                if (!pressedS) begin
                    state_d       = ST_RELEASE_WAIT;
                    debounceCnt_d = '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                    repeatCnt_d   = '0;
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                // Hold time keeps running so a release bounce does not reset it.
                if (holdCnt_q != LONG_SAT) begin
                    holdCnt_d = holdCnt_q + CNT_ONE;
                end
                if (pressedS) begin
                    state_d = ST_HELD;
                end else if (debounceCnt_q == DEB_LAST) begin
                    state_d        = ST_IDLE;
                    level_d        = 1'b0;
                    releasePulse_d = 1'b1;
                end else begin
                    debounceCnt_d = debounceCnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            debounceCnt_q  <= '0;
            holdCnt_q      <= '0;
            level_q        <= 1'b0;
            pressPulse_q   <= 1'b0;
            releasePulse_q <= 1'b0;
            longPulse_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            debounceCnt_q  <= debounceCnt_d;
            holdCnt_q      <= holdCnt_d;
            level_q        <= level_d;
            pressPulse_q   <= pressPulse_d;
            releasePulse_q <= releasePulse_d;
            longPulse_q    <= longPulse_d;
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeatCnt_q <= '0;
        end else begin
            repeatCnt_q <= repeatCnt_d;
        end
    end
`endif

    assign level         = level_q;
    assign press_pulse   = pressPulse_q;
    assign release_pulse = releasePulse_q;
    assign long_pulse    = longPulse_q;

endmodule
